// File: rtl/phase_window_gen.sv
// phase_window_gen
// Holds a sliding window of 2**DEPTH reference phase samples. For every
// accepted query phase it presents, one cycle later, the modular error
// (query - window[k]) for every slot together with that slot's absolute
// sample index, as a parallel vector with a single-cycle valid.
module phase_window_gen #(
  parameter int DEPTH      = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear_i,
  input  logic [DATA_WIDTH-1:0]                  ref_phase_i,
  input  logic                                   ref_vld_i,
  output logic                                   ref_rdy_o,
  input  logic [DATA_WIDTH-1:0]                  query_phase_i,
  input  logic                                   query_vld_i,
  output logic                                   query_rdy_o,
  output logic [2**DEPTH-1:0][DATA_WIDTH-1:0]    error_o,
  output logic [2**DEPTH-1:0][DATA_WIDTH-1:0]    pos_o,
  output logic                                   vld_o,
  output logic                                   window_full_o
);

  localparam int N = 2**DEPTH;
  localparam logic [DEPTH:0] CNT_FULL = (DEPTH+1)'(N);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_FULL
  } state_t;

  state_t                          state_q, state_d;
  logic [DEPTH:0]                  count_q, count_d;
  logic [DATA_WIDTH-1:0]           base_q, base_d;
  logic signed [DATA_WIDTH-1:0]    win_q [N];
  logic                            en_q;
  logic                            full_q;
  logic                            vld_q;
  logic [N-1:0][DATA_WIDTH-1:0]    err_q;
  logic [N-1:0][DATA_WIDTH-1:0]    pos_q;
  logic                            ref_acc;
  logic                            qry_acc;

  // Phase is circular: the error wraps modulo 2**DATA_WIDTH, never saturates.
  function automatic logic signed [DATA_WIDTH-1:0] phase_err(
    input logic signed [DATA_WIDTH-1:0] qry,
    input logic signed [DATA_WIDTH-1:0] ref_s
  );
    return qry - ref_s;
  endfunction

  // A clear drops any concurrent reference or query transfer.
  assign ref_rdy_o     = en_q & ~clear_i;
  assign ref_acc       = ref_vld_i & ref_rdy_o;
  assign qry_acc       = query_vld_i & full_q & ~clear_i;
  assign query_rdy_o   = full_q;
  assign window_full_o = full_q;
  assign vld_o         = vld_q;
  assign error_o       = err_q;
  assign pos_o         = pos_q;

  // Next fill count, base index and window state for the coming edge.
  always_comb begin
    count_d = count_q;
    base_d  = base_q;
    state_d = state_q;
    if (clear_i) begin
      count_d = '0;
      base_d  = '0;
    end else if (ref_acc) begin
      if (state_q == S_FULL) begin
        base_d = base_q + DATA_WIDTH'(1);
      end else begin
        count_d = count_q + (DEPTH+1)'(1);
      end
    end
    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == CNT_FULL) begin
      state_d = S_FULL;
    end else begin
      state_d = S_FILL;
    end
  end

  // Control state, registered flags and the error/position result vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      base_q  <= '0;
      en_q    <= 1'b0;
      full_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= '0;
      pos_q   <= '0;
    end else begin
      en_q    <= 1'b1;
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      full_q  <= (count_d == CNT_FULL);
      vld_q   <= qry_acc;
      if (qry_acc) begin
        // Uses the window and base as they stand before this edge's shift.
        for (int k = 0; k < N; k++) begin
          err_q[k] <= phase_err(query_phase_i, win_q[k]);
          pos_q[k] <= base_q + DATA_WIDTH'(k);
        end
      end
    end
  end

  // Window storage: fill in arrival order, then slide oldest-out once full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        win_q[k] <= '0;
      end
    end else if (ref_acc) begin
      if (state_q == S_FULL) begin
        for (int k = 0; k < N-1; k++) begin
          win_q[k] <= win_q[k+1];
        end
        win_q[N-1] <= ref_phase_i;
      end else begin
        win_q[count_q[DEPTH-1:0]] <= ref_phase_i;
      end
    end
  end

endmodule

// File: tb/tb_phase_window_gen.sv
// Bench for phase_window_gen with DEPTH=2 (N=4), DATA_WIDTH=16.
module tb_phase_window_gen;

  localparam int DEPTH = 2;
  localparam int DW    = 16;
  localparam int N     = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clear_i;
  logic [DW-1:0]          ref_phase_i;
  logic                   ref_vld_i;
  logic                   ref_rdy_o;
  logic [DW-1:0]          query_phase_i;
  logic                   query_vld_i;
  logic                   query_rdy_o;
  logic [N-1:0][DW-1:0]   error_o;
  logic [N-1:0][DW-1:0]   pos_o;
  logic                   vld_o;
  logic                   window_full_o;

  phase_window_gen #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .ref_phase_i   (ref_phase_i),
    .ref_vld_i     (ref_vld_i),
    .ref_rdy_o     (ref_rdy_o),
    .query_phase_i (query_phase_i),
    .query_vld_i   (query_vld_i),
    .query_rdy_o   (query_rdy_o),
    .error_o       (error_o),
    .pos_o         (pos_o),
    .vld_o         (vld_o),
    .window_full_o (window_full_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the last N accepted samples, and how many were accepted since clear.
  logic [DW-1:0]        m_win[$];
  int                   m_seen;
  logic                 m_en;
  logic                 m_full;
  logic                 e_vld;
  logic [N-1:0][DW-1:0] e_err;
  logic [N-1:0][DW-1:0] e_pos;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic model_reset();
    m_win.delete();
    m_seen = 0;
    m_en   = 1'b0;
    m_full = 1'b0;
    e_vld  = 1'b0;
    e_err  = '0;
    e_pos  = '0;
  endtask

  task automatic check_all();
    chk("vld_o", 64'(vld_o), 64'(e_vld));
    chk("window_full_o", 64'(window_full_o), 64'(m_full));
    chk("query_rdy_o", 64'(query_rdy_o), 64'(m_full));
    chk("ref_rdy_o", 64'(ref_rdy_o), 64'(m_en & ~clear_i));
    chk("error_o", 64'(error_o), 64'(e_err));
    chk("pos_o", 64'(pos_o), 64'(e_pos));
  endtask

  // One clock: predict transfers from current inputs, advance, update model, compare.
  task automatic step();
    logic ra, qa;
    ra = ref_vld_i & m_en & ~clear_i;
    qa = query_vld_i & m_full & ~clear_i;
    @(posedge clk);
    #1;
    m_en = 1'b1;
    if (clear_i) begin
      m_win.delete();
      m_seen = 0;
      m_full = 1'b0;
      e_vld  = 1'b0;
    end else begin
      e_vld = qa;
      if (qa) begin
        for (int k = 0; k < N; k++) begin
          e_err[k] = query_phase_i - m_win[k];
          e_pos[k] = 16'(m_seen - N + k);
        end
      end
      if (ra) begin
        m_win.push_back(ref_phase_i);
        if (m_win.size() > N) void'(m_win.pop_front());
        m_seen++;
      end
      m_full = (m_win.size() == N);
    end
    check_all();
  endtask

  task automatic idle();
    ref_vld_i   = 1'b0;
    query_vld_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic push(input int v);
    idle();
    ref_vld_i   = 1'b1;
    ref_phase_i = 16'(v);
    step();
  endtask

  task automatic query(input int v);
    idle();
    query_vld_i   = 1'b1;
    query_phase_i = 16'(v);
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    clear_i       = 1'b0;
    ref_vld_i     = 1'b0;
    ref_phase_i   = '0;
    query_vld_i   = 1'b0;
    query_phase_i = '0;
    model_reset();

    // Reset state before any clock edge.
    #2;
    check_all();
    #10 rst_n = 1'b1;

    // First edge after release enables the reference input.
    step();
    chk("ref_rdy_after_release", 64'(ref_rdy_o), 64'(1));

    // Fill, then first query.
    push(10); push(20); push(30);
    push(40);
    chk("full_after_4th", 64'(query_rdy_o), 64'(1));
    query(25);
    chk("q25_err", 64'(error_o), v4(15, 5, -5, -15));
    chk("q25_pos", 64'(pos_o), v4(0, 1, 2, 3));
    chk("q25_vld", 64'(vld_o), 64'(1));
    idle(); step();
    chk("vld_one_cycle", 64'(vld_o), 64'(0));

    // Slide once, then query.
    push(50);
    query(45);
    chk("q45_err", 64'(error_o), v4(25, 15, 5, -5));
    chk("q45_pos", 64'(pos_o), v4(1, 2, 3, 4));

    // Same-cycle ref + query sees the pre-shift window.
    idle();
    ref_vld_i = 1'b1; ref_phase_i = 16'd60;
    query_vld_i = 1'b1; query_phase_i = 16'd45;
    step();
    chk("simul_err", 64'(error_o), v4(25, 15, 5, -5));
    chk("simul_pos", 64'(pos_o), v4(1, 2, 3, 4));
    query(45);
    chk("post_simul_err", 64'(error_o), v4(15, 5, -5, -15));
    chk("post_simul_pos", 64'(pos_o), v4(2, 3, 4, 5));

    // Clear with a pending query drops it.
    idle();
    clear_i = 1'b1; query_vld_i = 1'b1; query_phase_i = 16'd7;
    ref_vld_i = 1'b1; ref_phase_i = 16'd99;
    step();
    chk("clear_vld", 64'(vld_o), 64'(0));
    chk("clear_qrdy", 64'(query_rdy_o), 64'(0));

    // Error wraps modulo 2**16.
    for (int i = 0; i < N; i++) push(32767);
    query(-32768);
    chk("wrap_err", 64'(error_o), v4(1, 1, 1, 1));

    // Refill after clear: positions restart, no stale samples.
    idle(); clear_i = 1'b1; step();
    push(1); push(2); push(3); push(4);
    query(0);
    chk("refill_err", 64'(error_o), v4(-1, -2, -3, -4));
    chk("refill_pos", 64'(pos_o), v4(0, 1, 2, 3));

    // Randomized traffic, including queries while not full and occasional clears.
    for (int i = 0; i < 400; i++) begin
      clear_i       = ($urandom_range(0, 19) == 0);
      ref_vld_i     = $urandom_range(0, 1) == 1;
      ref_phase_i   = 16'($urandom);
      query_vld_i   = $urandom_range(0, 2) != 0;
      query_phase_i = 16'($urandom);
      step();
    end

    // Position counter wraps after 65536 further samples.
    idle(); clear_i = 1'b1; step();
    idle(); ref_vld_i = 1'b1;
    for (int i = 0; i < 65536 + N; i++) begin
      ref_phase_i = 16'($urandom);
      step();
    end
    query(16'h1234);
    chk("pos_wrap", 64'(pos_o), v4(0, 1, 2, 3));

    // Asynchronous reset between edges, mid-stream.
    push(5);
    query(9);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    idle();
    check_all();
    chk("async_rst_vld", 64'(vld_o), 64'(0));
    chk("async_rst_err", 64'(error_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_rdy_relaunch", 64'(ref_rdy_o), 64'(1));
    chk("rst_empty", 64'(window_full_o), 64'(0));
    push(100); push(200); push(300); push(400);
    query(250);
    chk("rst_refill_err", 64'(error_o), v4(150, 50, -50, -150));
    chk("rst_refill_pos", 64'(pos_o), v4(0, 1, 2, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
